// File: rtl/reel_speed_scheduler.sv
// Spin-cycle sequencer for one reel: ramps a clock-divider speed value up, holds it
// for a timed run, ramps it back down, and pulses the divider restart on spin start.
module reel_speed_scheduler #(
  parameter int MAX_SPEED  = 50000000,
  parameter int MIN_SPEED  = 1,
  parameter int TOP_SPEED  = 40,
  parameter int ACCEL_STEP = 1,
  parameter int DECEL_STEP = 1,
  parameter int RUN_TICKS  = 1000,
  parameter int RUN_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  output logic [25:0] speed,
  output logic        div_rst,
  output logic        spinning,
  output logic        done
);

  // TOP_SPEED can never exceed the divider numerator.
  localparam int TOP_CLAMP = (TOP_SPEED > MAX_SPEED) ? MAX_SPEED : TOP_SPEED;

  localparam logic [26:0] TOP_EXT   = 27'(TOP_CLAMP);
  localparam logic [26:0] ACCEL_EXT = 27'(ACCEL_STEP);
  localparam logic [26:0] FLOOR_EXT = 27'(MIN_SPEED) + 27'(DECEL_STEP);
  localparam logic [25:0] MIN_26    = 26'(MIN_SPEED);
  localparam logic [25:0] TOP_26    = 26'(TOP_CLAMP);
  localparam logic [25:0] DECEL_26  = 26'(DECEL_STEP);
  localparam logic [RUN_W-1:0] RUN_LOAD = (RUN_TICKS == 0) ? RUN_W'(1) : RUN_W'(RUN_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    RUN   = 2'd2,
    DECEL = 2'd3
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;

  logic [26:0] speed_ext;
  logic [26:0] accel_sum;
  logic [25:0] accel_speed;
  logic [25:0] decel_diff;
  logic [25:0] decel_speed;

  // Widened arithmetic so neither direction can wrap before clamping.
  assign speed_ext   = {1'b0, speed};
  assign accel_sum   = speed_ext + ACCEL_EXT;
  assign accel_speed = (accel_sum >= TOP_EXT) ? TOP_26 : accel_sum[25:0];
  assign decel_diff  = speed - DECEL_26;
  assign decel_speed = (speed_ext >= FLOOR_EXT) ? decel_diff : MIN_26;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      speed    <= MIN_26;
      div_rst  <= 1'b0;
      spinning <= 1'b0;
      done     <= 1'b0;
      run_cnt  <= '0;
    end else begin
      div_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCEL;
            speed    <= MIN_26;
            div_rst  <= 1'b1;
            spinning <= 1'b1;
          end
        end
        ACCEL: begin
          if (stop) begin
            state <= DECEL;
          end else if (tick) begin
            speed <= accel_speed;
            if (accel_speed == TOP_26) begin
              state   <= RUN;
              run_cnt <= RUN_LOAD;
            end
          end
        end
        RUN: begin
          // stop takes priority over tick and freezes the run counter.
          if (stop) begin
            state <= DECEL;
          end else if (tick) begin
            if (run_cnt <= RUN_W'(1)) begin
              state <= DECEL;
            end else begin
              run_cnt <= run_cnt - RUN_W'(1);
            end
          end
        end
        DECEL: begin
          if (tick) begin
            speed <= decel_speed;
            if (decel_speed == MIN_26) begin
              state    <= IDLE;
              done     <= 1'b1;
              spinning <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reel_speed_scheduler.sv
// Directed bench for reel_speed_scheduler: MIN=1, TOP=5, ACCEL=3, DECEL=1, RUN=3,
// plus a second instance with RUN_TICKS=0.
module tb_reel_speed_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic        start2 = 1'b0, stop2 = 1'b0, tick2 = 1'b0;
  logic [25:0] speed, speed2;
  logic        div_rst, spinning, done;
  logic        div_rst2, spinning2, done2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reel_speed_scheduler #(
    .MAX_SPEED(50000000), .MIN_SPEED(1), .TOP_SPEED(5),
    .ACCEL_STEP(3), .DECEL_STEP(1), .RUN_TICKS(3), .RUN_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
    .speed(speed), .div_rst(div_rst), .spinning(spinning), .done(done)
  );

  reel_speed_scheduler #(
    .MAX_SPEED(50000000), .MIN_SPEED(1), .TOP_SPEED(5),
    .ACCEL_STEP(3), .DECEL_STEP(1), .RUN_TICKS(0), .RUN_W(16)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .tick(tick2),
    .speed(speed2), .div_rst(div_rst2), .spinning(spinning2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-14s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus on the main instance; outputs sampled 1 time unit after the edge.
  task automatic cycle(input logic s, input logic p, input logic t);
    start = s; stop = p; tick = t;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic cycle2(input logic s, input logic p, input logic t);
    start2 = s; stop2 = p; tick2 = t;
    @(posedge clk); #1;
    start2 = 1'b0; stop2 = 1'b0; tick2 = 1'b0;
  endtask

  task automatic check_all(input string tag, input int sp, input logic dr,
                           input logic spn, input logic dn);
    check({tag, ".speed"}, 32'(speed), 32'(sp));
    check({tag, ".div_rst"}, 32'(div_rst), 32'(dr));
    check({tag, ".spinning"}, 32'(spinning), 32'(spn));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    // 1. Reset with random inputs, then idle after release.
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); stop = 1'($urandom); tick = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    check_all("rst", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
    check_all("idle10", 1, 1'b0, 1'b0, 1'b0);

    // 2. Full spin.
    cycle(1'b1, 1'b0, 1'b0);
    check_all("t2.start", 1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2.div_rst_off", 32'(div_rst), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t2.acc1", 32'(speed), 32'd4);
    cycle(1'b0, 1'b0, 1'b1);
    check("t2.acc2", 32'(speed), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check("t2.run", 32'(speed), 32'd5);
    end
    for (int i = 4; i >= 2; i--) begin
      cycle(1'b0, 1'b0, 1'b1);
      check_all("t2.dec", i, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1);
    check_all("t2.done", 1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("t2.done_off", 32'(done), 32'd0);

    // 3. Early stop in ACCEL together with tick.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t3.acc1", 32'(speed), 32'd4);
    cycle(1'b0, 1'b1, 1'b1);
    check_all("t3.stop", 4, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t3.dec3", 32'(speed), 32'd3);
    cycle(1'b0, 1'b0, 1'b1);
    check("t3.dec2", 32'(speed), 32'd2);
    cycle(1'b0, 1'b0, 1'b1);
    check_all("t3.done", 1, 1'b0, 1'b0, 1'b1);

    // 4. stop beats tick in RUN; start ignored during DECEL.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4.run", 32'(speed), 32'd5);
    cycle(1'b0, 1'b1, 1'b1);
    check("t4.stop", 32'(speed), 32'd5);
    cycle(1'b1, 1'b0, 1'b0);
    check_all("t4.start_ign", 5, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4.dec4", 32'(speed), 32'd4);
    cycle(1'b1, 1'b0, 1'b1);
    check_all("t4.dec3", 3, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_all("t4.done", 1, 1'b0, 1'b0, 1'b1);

    // 5a. Ticks spaced 7 cycles apart.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    check("t5.pre_tick1", 32'(speed), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5.tick1", 32'(speed), 32'd4);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    check("t5.pre_tick2", 32'(speed), 32'd4);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5.tick2", 32'(speed), 32'd5);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 3; i >= 1; i--) begin
      for (int j = 0; j < 6; j++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check("t5.dec", 32'(speed), 32'(i + 1));
    end
    for (int j = 0; j < 6; j++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_all("t5.done", 1, 1'b0, 1'b0, 1'b1);

    // 5b. RUN_TICKS=0 instance: RUN lasts one tick.
    cycle2(1'b1, 1'b0, 1'b0);
    cycle2(1'b0, 1'b0, 1'b1);
    cycle2(1'b0, 1'b0, 1'b1);
    check("t5b.top", 32'(speed2), 32'd5);
    cycle2(1'b0, 1'b0, 1'b1);
    check("t5b.run1", 32'(speed2), 32'd5);
    cycle2(1'b0, 1'b0, 1'b1);
    check("t5b.dec4", 32'(speed2), 32'd4);
    for (int i = 0; i < 3; i++) cycle2(1'b0, 1'b0, 1'b1);
    check("t5b.done", 32'(done2), 32'd1);
    check("t5b.speed1", 32'(speed2), 32'd1);

    // 5c. start and stop together in IDLE: start wins.
    cycle(1'b1, 1'b1, 1'b0);
    check_all("t5c.start", 1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5c.acc", 32'(speed), 32'd4);

    // 6. Asynchronous reset during DECEL at speed 3.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t6.dec3", 32'(speed), 32'd3);
    #2 rst = 1'b0;
    #1;
    check_all("t6.async", 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    check_all("t6.held", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    check_all("t6.restart", 1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t6.acc", 32'(speed), 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reel_speed_scheduler.md
Name: reel_speed_scheduler

Overview:
Sequences one reel's clock_divider-style speed input through a spin cycle: spin-up ramp, timed full-speed run, spin-down ramp, stop. The block drives the divider's `speed` input and its restart pulse, so a divider downstream never sees a zero divisor. Speed changes only on an external step strobe (e.g. a 1 kHz enable). One instance sits per reel, between the game FSM and that reel's divider.

Parameters:
MAX_SPEED, 50000000, divider numerator; upper bound for every speed value
MIN_SPEED, 1, idle/stopped speed; legal range 1..TOP_SPEED
TOP_SPEED, 40, full-spin speed; legal range MIN_SPEED..MAX_SPEED
ACCEL_STEP, 1, speed increment per tick in ACCEL; must be >= 1
DECEL_STEP, 1, speed decrement per tick in DECEL; must be >= 1
RUN_TICKS, 1000, ticks spent at TOP_SPEED before automatic spin-down; 0 is treated as 1
RUN_W, 16, width of the run counter; RUN_TICKS must fit in RUN_W bits

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request to begin a spin; honoured only in IDLE
stop  input  1  one-cycle request to begin spin-down early; honoured in ACCEL and RUN
tick  input  1  one-cycle step strobe; ramps and the run counter advance only on cycles where tick=1
speed  output  26  registered speed value for the divider; always within MIN_SPEED..TOP_SPEED
div_rst  output  1  registered one-cycle pulse restarting the divider counter
spinning  output  1  high in ACCEL, RUN and DECEL
done  output  1  registered one-cycle pulse when spin-down completes

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, speed=MIN_SPEED, div_rst=0, spinning=0, done=0, run counter=0. Release of rst is sampled synchronously.
- States: IDLE, ACCEL, RUN, DECEL. All outputs are registered; each reflects the state or speed reached at the same clock edge.
- IDLE:
  - start=1 -> ACCEL next edge; speed reloaded to MIN_SPEED; div_rst=1 for exactly that one cycle.
  - stop and tick are ignored in IDLE.
  - start and stop in the same cycle: start wins.
- ACCEL:
  - stop=1 -> DECEL next edge, regardless of tick; speed is unchanged that cycle.
  - Otherwise, on tick: speed = min(speed+ACCEL_STEP, TOP_SPEED).
  - When the new speed equals TOP_SPEED -> RUN; run counter loaded with max(RUN_TICKS,1).
- RUN:
  - stop=1 -> DECEL next edge; stop has priority over tick, and the counter does not decrement that cycle.
  - On tick with counter <= 1 -> DECEL; otherwise on tick, counter decrements.
  - speed is held at TOP_SPEED throughout RUN.
- DECEL:
  - On tick: speed = max(speed-DECEL_STEP, MIN_SPEED).
  - When the new speed equals MIN_SPEED -> IDLE, with done=1 and spinning=0 at that same edge; done lasts one cycle.
  - If DECEL is entered already at MIN_SPEED, completion occurs on the next tick.
  - start and stop are ignored in DECEL.
- Latency: a tick in cycle N is reflected in speed at edge N+1. start-to-spinning is 1 cycle.
- Arithmetic: add and subtract in 27 bits, then clamp; results never wrap and never reach 0.
- start is ignored whenever state != IDLE; no queueing.
- div_rst is high only on IDLE->ACCEL; no other transition pulses it.
- tick asserted for multiple consecutive cycles: one step per cycle.
- Reset mid-spin: immediate return to the reset values above. No done pulse is issued.

Test Plan:
Set MIN_SPEED=1, TOP_SPEED=5, ACCEL_STEP=3, DECEL_STEP=1, RUN_TICKS=3 unless stated.
1. Assert rst=0 with random inputs -> speed=1, div_rst=0, spinning=0, done=0; release rst, 10 cycles idle -> outputs unchanged.
2. Full spin:
   - start pulse -> div_rst high for 1 cycle, spinning=1.
   - ticks -> speed 4, then 5 (clamped); state RUN.
   - 3 ticks -> speed stays 5, then DECEL.
   - 4 ticks -> speed 4, 3, 2, 1; done=1 for one cycle at the edge speed becomes 1, spinning=0.
3. Early stop: start, one tick (speed=4), then stop with tick in the same cycle -> speed stays 4, DECEL; ticks -> 3, 2, 1, done pulse.
4. RUN priority: in RUN with counter=3, assert stop and tick together -> DECEL, speed 5 held that cycle; start pulses during DECEL ignored, no div_rst.
5. Spacing and edge parameters:
   - Ticks spaced 7 cycles apart -> speed changes exactly 1 cycle after each tick.
   - RUN_TICKS=0 -> RUN lasts exactly 1 tick.
   - start and stop together in IDLE -> spin starts.
6. Reset mid-operation: rst=0 during DECEL at speed=3 -> speed=1, spinning=0 asynchronously; done never pulses. A start after release spins normally.
